id_ex_stage: RTL and testbench

Decode-to-execute pipeline stage of the pipelined DLX datapath. Sits directly downstream of the decode-stage main control block and captures its 13 control signals together with operand data, immediates and register specifiers on each clock. Detects load-use hazards between the instruction in EX and the instruction in ID, then stalls fetch/decode and inserts a bubble. Clears itself on a taken branch/jump flush from EX.

---
 rtl/id_ex_stage.sv | 205 ++++++++++++++++++++
 tb/tb_id_ex_stage.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register of the DLX datapath with load-use hazard stall and EX flush.
// Optional feature: define HAZARD_DETECT_EN to enable load-use detection and stall_cnt.
module id_ex_stage #(
    parameter int DW       = 32,
    parameter int RW       = 5,
    parameter int LINK_REG = 31
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          id_valid,
    input  logic          id_RegDst,
    input  logic          id_ALUSrc,
    input  logic          id_MemtoReg,
    input  logic          id_RegWrite,
    input  logic          id_MemWrite,
    input  logic          id_BranchEQZ,
    input  logic          id_BranchNEZ,
    input  logic          id_JumpR,
    input  logic          id_Jump,
    input  logic          id_JumpAL,
    input  logic          id_ExtOp,
    input  logic          id_LoadExtOp,
    input  logic          id_MemRead,
    input  logic [DW-1:0] id_pc4,
    input  logic [DW-1:0] id_busA,
    input  logic [DW-1:0] id_busB,
    input  logic [DW-1:0] id_imm,
    input  logic [RW-1:0] id_rs1,
    input  logic [RW-1:0] id_rs2,
    input  logic [RW-1:0] id_rd,
    input  logic          ex_flush,
    output logic          ex_valid,
    output logic          ex_RegDst,
    output logic          ex_ALUSrc,
    output logic          ex_MemtoReg,
    output logic          ex_RegWrite,
    output logic          ex_MemWrite,
    output logic          ex_BranchEQZ,
    output logic          ex_BranchNEZ,
    output logic          ex_JumpR,
    output logic          ex_Jump,
    output logic          ex_JumpAL,
    output logic          ex_ExtOp,
    output logic          ex_LoadExtOp,
    output logic          ex_MemRead,
    output logic [DW-1:0] ex_pc4,
    output logic [DW-1:0] ex_busA,
    output logic [DW-1:0] ex_busB,
    output logic [DW-1:0] ex_imm,
    output logic [RW-1:0] ex_rs1,
    output logic [RW-1:0] ex_rs2,
    output logic [RW-1:0] ex_rd,
    output logic [RW-1:0] ex_dst,
    output logic          pc_write,
    output logic          ifid_write,
    output logic [15:0]   stall_cnt
);

    typedef struct packed {
        logic reg_dst;
        logic alu_src;
        logic memto_reg;
        logic reg_write;
        logic mem_write;
        logic branch_eqz;
        logic branch_nez;
        logic jump_r;
        logic jump;
        logic jump_al;
        logic ext_op;
        logic load_ext_op;
        logic mem_read;
    } ctrl_t;

    ctrl_t         id_ctrl;
    ctrl_t         ex_ctrl_q, ex_ctrl_d;
    logic          ex_valid_q, ex_valid_d;
    logic [DW-1:0] ex_pc4_q, ex_busA_q, ex_busB_q, ex_imm_q;
    logic [RW-1:0] ex_rs1_q, ex_rs2_q, ex_rd_q;
    logic [RW-1:0] ex_dst_q, ex_dst_d;
    logic          hazard;
    logic          bubble;

    assign id_ctrl = '{
        reg_dst:     id_RegDst,
        alu_src:     id_ALUSrc,
        memto_reg:   id_MemtoReg,
        reg_write:   id_RegWrite,
        mem_write:   id_MemWrite,
        branch_eqz:  id_BranchEQZ,
        branch_nez:  id_BranchNEZ,
        jump_r:      id_JumpR,
        jump:        id_Jump,
        jump_al:     id_JumpAL,
        ext_op:      id_ExtOp,
        load_ext_op: id_LoadExtOp,
        mem_read:    id_MemRead
    };

`ifdef HAZARD_DETECT_EN
    logic        rs1_used, rs2_used;
    logic [15:0] stall_cnt_q, stall_cnt_d;

    // J and JAL carry no source register; stores read rs2 as the store data.
    assign rs1_used = ~((id_Jump | id_JumpAL) & ~id_JumpR);
    assign rs2_used = ~id_RegDst | id_MemWrite;

    assign hazard = ex_valid_q & ex_ctrl_q.mem_read & (ex_dst_q != '0) & id_valid &
                    ((rs1_used & (id_rs1 == ex_dst_q)) | (rs2_used & (id_rs2 == ex_dst_q)));

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (hazard && !ex_flush && stall_cnt_q != 16'hFFFF) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
`else
    assign hazard    = 1'b0;
    assign stall_cnt = '0;
`endif

    // A flush discards the stalled ID instruction, so it releases the stall.
    assign bubble     = ex_flush | hazard;
    assign pc_write   = ~hazard | ex_flush;
    assign ifid_write = ~hazard | ex_flush;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        ex_valid_d = id_valid;
        ex_ctrl_d  = id_valid ? id_ctrl : '0;
        if (bubble) begin
            ex_valid_d = 1'b0;
            ex_ctrl_d  = '0;
        end
        if (id_JumpAL) begin
            ex_dst_d = RW'(LINK_REG);
        end else if (id_RegDst) begin
            ex_dst_d = id_rs2;
        end else begin
            ex_dst_d = id_rd;
        end
    end

    // Data fields load every edge; a bubble only has to clear valid and control.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: non-blocking assignments model registers; blocking here would race.
            ex_valid_q <= 1'b0;
            ex_ctrl_q  <= '0;
            ex_pc4_q   <= '0;
            ex_busA_q  <= '0;
            ex_busB_q  <= '0;
            ex_imm_q   <= '0;
            ex_rs1_q   <= '0;
            ex_rs2_q   <= '0;
            ex_rd_q    <= '0;
            ex_dst_q   <= '0;
        end else begin
            ex_valid_q <= ex_valid_d;
            ex_ctrl_q  <= ex_ctrl_d;
            ex_pc4_q   <= id_pc4;
            ex_busA_q  <= id_busA;
            ex_busB_q  <= id_busB;
            ex_imm_q   <= id_imm;
            ex_rs1_q   <= id_rs1;
            ex_rs2_q   <= id_rs2;
            ex_rd_q    <= id_rd;
            ex_dst_q   <= ex_dst_d;
        end
    end

    assign ex_valid     = ex_valid_q;
    assign ex_RegDst    = ex_ctrl_q.reg_dst;
    assign ex_ALUSrc    = ex_ctrl_q.alu_src;
    assign ex_MemtoReg  = ex_ctrl_q.memto_reg;
    assign ex_RegWrite  = ex_ctrl_q.reg_write;
    assign ex_MemWrite  = ex_ctrl_q.mem_write;
    assign ex_BranchEQZ = ex_ctrl_q.branch_eqz;
    assign ex_BranchNEZ = ex_ctrl_q.branch_nez;
    assign ex_JumpR     = ex_ctrl_q.jump_r;
    assign ex_Jump      = ex_ctrl_q.jump;
    assign ex_JumpAL    = ex_ctrl_q.jump_al;
    assign ex_ExtOp     = ex_ctrl_q.ext_op;
    assign ex_LoadExtOp = ex_ctrl_q.load_ext_op;
    assign ex_MemRead   = ex_ctrl_q.mem_read;
    assign ex_pc4       = ex_pc4_q;
    assign ex_busA      = ex_busA_q;
    assign ex_busB      = ex_busB_q;
    assign ex_imm       = ex_imm_q;
    assign ex_rs1       = ex_rs1_q;
    assign ex_rs2       = ex_rs2_q;
    assign ex_rd        = ex_rd_q;
    assign ex_dst       = ex_dst_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: directed DLX sequences plus random traffic vs. a behavioural model.
// Hazard expectations follow HAZARD_DETECT_EN exactly as the design is built.
module tb_id_ex_stage;

    typedef struct packed {
        logic reg_dst, alu_src, memto_reg, reg_write, mem_write, br_eqz, br_nez;
        logic jump_r, jump, jump_al, ext_op, load_ext_op, mem_read;
    } ctrl_t;

    typedef struct {
        logic        valid;
        ctrl_t       c;
        logic [31:0] pc4, busa, busb, imm;
        logic [4:0]  rs1, rs2, rd;
    } instr_t;

    typedef struct {
        logic        valid;
        ctrl_t       c;
        logic        chk_data;
        logic [31:0] pc4, busa, busb, imm;
        logic [4:0]  rs1, rs2, rd, dst;
        logic [15:0] cnt;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    instr_t      cur;
    logic        ex_flush = 1'b0;
    logic        ex_valid, pc_write, ifid_write;
    ctrl_t       ex_c;
    logic [31:0] ex_pc4, ex_busA, ex_busB, ex_imm;
    logic [4:0]  ex_rs1, ex_rs2, ex_rd, ex_dst;
    logic [15:0] stall_cnt;

    int n_checks = 0;
    int n_fail   = 0;
    exp_t exp_q[$];

    // Behavioural model: the instruction currently sitting in EX and the bubble count.
    logic       m_valid;
    logic       m_load;
    logic [4:0] m_dst;
    int         m_cnt;

    always #5 clk = ~clk;

    id_ex_stage #(.DW(32), .RW(5), .LINK_REG(31)) dut (
        .clk(clk), .rst_n(rst_n), .id_valid(cur.valid),
        .id_RegDst(cur.c.reg_dst), .id_ALUSrc(cur.c.alu_src), .id_MemtoReg(cur.c.memto_reg),
        .id_RegWrite(cur.c.reg_write), .id_MemWrite(cur.c.mem_write),
        .id_BranchEQZ(cur.c.br_eqz), .id_BranchNEZ(cur.c.br_nez), .id_JumpR(cur.c.jump_r),
        .id_Jump(cur.c.jump), .id_JumpAL(cur.c.jump_al), .id_ExtOp(cur.c.ext_op),
        .id_LoadExtOp(cur.c.load_ext_op), .id_MemRead(cur.c.mem_read),
        .id_pc4(cur.pc4), .id_busA(cur.busa), .id_busB(cur.busb), .id_imm(cur.imm),
        .id_rs1(cur.rs1), .id_rs2(cur.rs2), .id_rd(cur.rd), .ex_flush(ex_flush),
        .ex_valid(ex_valid),
        .ex_RegDst(ex_c.reg_dst), .ex_ALUSrc(ex_c.alu_src), .ex_MemtoReg(ex_c.memto_reg),
        .ex_RegWrite(ex_c.reg_write), .ex_MemWrite(ex_c.mem_write),
        .ex_BranchEQZ(ex_c.br_eqz), .ex_BranchNEZ(ex_c.br_nez), .ex_JumpR(ex_c.jump_r),
        .ex_Jump(ex_c.jump), .ex_JumpAL(ex_c.jump_al), .ex_ExtOp(ex_c.ext_op),
        .ex_LoadExtOp(ex_c.load_ext_op), .ex_MemRead(ex_c.mem_read),
        .ex_pc4(ex_pc4), .ex_busA(ex_busA), .ex_busB(ex_busB), .ex_imm(ex_imm),
        .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_dst(ex_dst),
        .pc_write(pc_write), .ifid_write(ifid_write), .stall_cnt(stall_cnt)
    );

    task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic instr_t blank();
        instr_t i;
        i.valid = 1'b1; i.c = '0;
        i.pc4 = 32'h100; i.busa = 32'h0; i.busb = 32'h0; i.imm = 32'h0;
        i.rs1 = 5'd0; i.rs2 = 5'd0; i.rd = 5'd0;
        return i;
    endfunction

    function automatic instr_t lw(input logic [4:0] base, input logic [4:0] dst);
        instr_t i = blank();
        i.c.reg_dst = 1; i.c.alu_src = 1; i.c.memto_reg = 1; i.c.reg_write = 1;
        i.c.mem_read = 1; i.c.ext_op = 1;
        i.rs1 = base; i.rs2 = dst; i.imm = 32'h4; i.pc4 = 32'h200;
        return i;
    endfunction

    function automatic instr_t rtype(input logic [4:0] d, input logic [4:0] a, input logic [4:0] b);
        instr_t i = blank();
        i.c.reg_write = 1; i.rs1 = a; i.rs2 = b; i.rd = d;
        i.busa = 32'h1111_0000; i.busb = 32'h0000_2222; i.pc4 = 32'h204;
        return i;
    endfunction

    function automatic instr_t rnd();
        instr_t i;
        i.valid = ($urandom_range(0, 7) != 0);
        i.c = ctrl_t'($urandom);
        i.c.mem_read = ($urandom_range(0, 2) == 0);
        i.c.jump = ($urandom_range(0, 5) == 0);
        i.c.jump_al = ($urandom_range(0, 7) == 0);
        i.c.jump_r = ($urandom_range(0, 7) == 0);
        i.pc4 = $urandom; i.busa = $urandom; i.busb = $urandom; i.imm = $urandom;
        i.rs1 = 5'($urandom_range(0, 7)); i.rs2 = 5'($urandom_range(0, 7));
        i.rd = 5'($urandom_range(0, 7));
        return i;
    endfunction

    // Load-use rule: a valid load in EX writing a nonzero register that ID actually reads.
    function automatic logic model_hazard(input instr_t i);
`ifdef HAZARD_DETECT_EN
        logic reads1, reads2;
        if (!(m_valid && m_load && m_dst != 0 && i.valid)) return 1'b0;
        reads1 = !((i.c.jump || i.c.jump_al) && !i.c.jump_r);
        reads2 = !i.c.reg_dst || i.c.mem_write;
        return (reads1 && i.rs1 == m_dst) || (reads2 && i.rs2 == m_dst);
`else
        return (i.valid && 1'b0);
`endif
    endfunction

    task automatic model_reset();
        m_valid = 1'b0; m_load = 1'b0; m_dst = 5'd0; m_cnt = 0;
    endtask

    // Drive one ID instruction, check the stall outputs, and queue the EX state expected next edge.
    task automatic drive(input instr_t i, input logic fl);
        logic hz;
        exp_t e;
        @(negedge clk);
        cur = i;
        ex_flush = fl;
        #1;
        hz = model_hazard(i);
        check("pc_write", pc_write, !hz || fl);
        check("ifid_write", ifid_write, !hz || fl);
        if (hz && !fl && m_cnt < 65535) m_cnt++;
        e.cnt = 16'(m_cnt);
        e.pc4 = i.pc4; e.busa = i.busa; e.busb = i.busb; e.imm = i.imm;
        e.rs1 = i.rs1; e.rs2 = i.rs2; e.rd = i.rd;
        e.dst = i.c.jump_al ? 5'd31 : (i.c.reg_dst ? i.rs2 : i.rd);
        if (hz || fl) begin
            e.valid = 1'b0; e.c = '0; e.chk_data = 1'b0;
        end else begin
            e.valid = i.valid; e.c = i.valid ? i.c : '0; e.chk_data = 1'b1;
        end
        exp_q.push_back(e);
        m_valid = e.valid;
        m_load = e.c.mem_read;
        m_dst = e.dst;
    endtask

    task automatic check_cleared(input string tag);
        check({tag, "_valid"}, ex_valid, 1'b0);
        check({tag, "_ctrl"}, ex_c, 13'd0);
        check({tag, "_data"}, {ex_pc4, ex_busA, ex_busB, ex_imm}, 128'd0);
        check({tag, "_regs"}, {ex_rs1, ex_rs2, ex_rd, ex_dst}, 20'd0);
        check({tag, "_cnt"}, stall_cnt, 16'd0);
        check({tag, "_pc_write"}, {pc_write, ifid_write}, 2'b11);
    endtask

    // Monitor: after every rising edge, compare DUT EX outputs with the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (rst_n && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("ex_valid", ex_valid, e.valid);
                check("ex_ctrl", ex_c, e.c);
                check("stall_cnt", stall_cnt, e.cnt);
                if (e.chk_data) begin
                    check("ex_dst", ex_dst, e.dst);
                    check("ex_data", {ex_pc4, ex_busA, ex_busB, ex_imm},
                          {e.pc4, e.busa, e.busb, e.imm});
                    check("ex_regs", {ex_rs1, ex_rs2, ex_rd}, {e.rs1, e.rs2, e.rd});
                end
            end
        end
    end

    initial begin
        instr_t i;
        cur = blank();
        cur.valid = 1'b1;
        model_reset();
        #3;
        check_cleared("reset0");
        @(negedge clk);
        rst_n = 1'b1;

        // ADDI r7 <- imm 0x10
        i = blank();
        i.c.reg_dst = 1; i.c.alu_src = 1; i.c.reg_write = 1; i.c.ext_op = 1;
        i.rs1 = 5'd3; i.rs2 = 5'd7; i.rd = 5'd9; i.imm = 32'h0000_0010;
        drive(i, 0);

        // LW r5 then ADD r1,r5,r2: one bubble, then the ADD is captured.
        drive(lw(5'd2, 5'd5), 0);
        drive(rtype(5'd1, 5'd5, 5'd2), 0);
        drive(rtype(5'd1, 5'd5, 5'd2), 0);

        // LW r0 then a consumer of r0: no stall.
        drive(lw(5'd2, 5'd0), 0);
        drive(rtype(5'd4, 5'd0, 5'd0), 0);

        // LW r5 then J whose rs1 field is 5: no stall.
        drive(lw(5'd2, 5'd5), 0);
        i = blank(); i.c.jump = 1; i.rs1 = 5'd5; i.rs2 = 5'd6;
        drive(i, 0);

        // LW r5 then SW storing r5 through rs2: stall.
        drive(lw(5'd2, 5'd5), 0);
        i = blank(); i.c.reg_dst = 1; i.c.alu_src = 1; i.c.mem_write = 1; i.c.ext_op = 1;
        i.rs1 = 5'd3; i.rs2 = 5'd5; i.imm = 32'h8;
        drive(i, 0);
        drive(i, 0);

        // Hazard coincident with flush: flush wins, counter holds.
        drive(lw(5'd2, 5'd6), 0);
        drive(rtype(5'd1, 5'd6, 5'd6), 1);

        // JAL resolves to the link register.
        i = blank(); i.c.jump_al = 1; i.c.reg_write = 1; i.rs1 = 5'd1; i.rs2 = 5'd2; i.rd = 5'd3;
        drive(i, 0);

        for (int n = 0; n < 1500; n++) begin
            drive(rnd(), ($urandom_range(0, 9) == 0));
        end

`ifdef HAZARD_DETECT_EN
        // Self-dependent load repeats a hazard every other cycle until the counter saturates.
        begin
            instr_t ld;
            int guard = 0;
            ld = lw(5'd5, 5'd5);
            while (m_cnt < 65535 && guard < 140000) begin
                drive(ld, 0);
                guard++;
            end
            for (int n = 0; n < 6; n++) drive(ld, 0);
            @(negedge clk);
            check("stall_cnt_sat", stall_cnt, 16'hFFFF);
        end
`else
        drive(lw(5'd2, 5'd5), 0);
        drive(rtype(5'd1, 5'd5, 5'd2), 0);
        @(negedge clk);
        check("stall_cnt_off", stall_cnt, 16'd0);
`endif

        // Asynchronous reset mid-stream with a valid instruction in ID.
        drive(rtype(5'd1, 5'd2, 5'd3), 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        cur = rnd();
        cur.valid = 1'b1;
        #1;
        rst_n = 1'b0;
        #1;
        check_cleared("reset_mid");
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        drive(lw(5'd2, 5'd5), 0);
        drive(rtype(5'd1, 5'd5, 5'd2), 0);
        drive(rtype(5'd1, 5'd5, 5'd2), 0);

        repeat (4) @(posedge clk);
        #2;
        check("scoreboard_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
